// File: rtl/bsg_wormhole_concentrator_in_cid_pkg.sv
// Shared types and helpers for the cid-stamping wormhole input concentrator.
//   ch_state_e     : per-input packet framing state (header expected / body in flight)
//   arb_state_e    : output arbiter state (free to grant / locked to one input)
//   safe_clog2     : index width that never collapses to zero bits
package bsg_wormhole_concentrator_in_cid_pkg;

   typedef enum logic {ChHdr, ChBody} ch_state_e;

   typedef enum logic {ArbFree, ArbLocked} arb_state_e;

   // arb_mode_p encoding; any other value selects round-robin
   localparam int unsigned ArbFixedPriority = 1;

   function automatic int unsigned safe_clog2(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bsg_wormhole_concentrator_in_cid_ch.sv
// One input channel of the concentrator: a small registered FIFO plus the
// header/body length tracker that frames wormhole packets.
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_v, i_data        upstream flit valid/data
//   o_ready            upstream ready (low only while the FIFO is full or in reset)
//   o_v, o_data        FIFO head valid/data (o_v doubles as the output request)
//   o_is_hdr           head flit is a header
//   i_yumi             head is consumed this cycle
//   o_release          the consumed flit is the last flit of its packet
module bsg_wormhole_concentrator_in_cid_ch
   import bsg_wormhole_concentrator_in_cid_pkg::*;
#(
   parameter int unsigned flit_width_p = 16,
   parameter int unsigned len_width_p  = 3,
   parameter int unsigned cord_width_p = 4,
   parameter int unsigned cid_width_p  = 3,
   parameter int unsigned fifo_els_p   = 2
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_v,
   input  logic [flit_width_p-1:0] i_data,
   output logic                    o_ready,
   output logic                    o_v,
   output logic [flit_width_p-1:0] o_data,
   output logic                    o_is_hdr,
   input  logic                    i_yumi,
   output logic                    o_release
);

   localparam int unsigned PtrW   = safe_clog2(fifo_els_p);
   localparam int unsigned CntW   = $clog2(fifo_els_p + 1);
   localparam int unsigned LenLsb = cord_width_p + cid_width_p;

   logic [flit_width_p-1:0] r_mem [fifo_els_p];
   logic [PtrW-1:0]         r_wptr;
   logic [PtrW-1:0]         r_rptr;
   logic [CntW-1:0]         r_count;
   ch_state_e               r_state;
   ch_state_e               w_state_next;
   logic [len_width_p-1:0]  r_rem;
   logic [len_width_p-1:0]  w_rem_next;
   logic [len_width_p-1:0]  w_len;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_enq;
   logic                    w_deq;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(fifo_els_p - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_full   = (r_count == CntW'(fifo_els_p));
   assign w_empty  = (r_count == '0);
   // Gating with reset keeps ready/valid low while reset is held.
   assign o_ready  = i_reset_n & ~w_full;
   assign o_v      = i_reset_n & ~w_empty;
   assign w_enq    = i_v & o_ready;
   assign w_deq    = i_yumi & o_v;
   assign o_data   = r_mem[r_rptr];
   assign o_is_hdr = (r_state == ChHdr);
   assign w_len    = o_data[LenLsb +: len_width_p];

   // Storage needs no reset: occupancy is tracked by r_count.
   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_wptr <= ptr_inc(r_wptr);
         if (w_deq) r_rptr <= ptr_inc(r_rptr);
         if (w_enq && !w_deq) begin
            r_count <= r_count + 1'b1;
         end else if (!w_enq && w_deq) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rem_next   = r_rem;
      o_release    = 1'b0;
      if (w_deq) begin
         unique case (r_state)
            ChHdr: begin
               if (w_len == '0) begin
                  o_release = 1'b1;
               end else begin
                  w_state_next = ChBody;
                  w_rem_next   = w_len;
               end
            end
            ChBody: begin
               if (r_rem != '0) w_rem_next = r_rem - 1'b1;
               if (r_rem == len_width_p'(1)) begin
                  o_release    = 1'b1;
                  w_state_next = ChHdr;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= ChHdr;
         r_rem   <= '0;
      end else begin
         r_state <= w_state_next;
         r_rem   <= w_rem_next;
      end
   end

endmodule

// File: rtl/bsg_wormhole_concentrator_in_cid.sv
// N-to-1 wormhole concentrator. Each input is buffered in its own channel; a
// packet-granular arbiter (round-robin or fixed priority) locks the output to
// one input from header to last body flit, and optionally stamps the input
// index into the header cid field.
// Ports:
//   clk_i, reset_n_i                   clock, synchronous active-low reset
//   links_v_i / links_data_i           per-input flit valid/data (input i at [i*W +: W])
//   links_ready_and_rev_o              per-input ready
//   concentrated_link_v_o / _data_o    merged output flit (data is zero when not valid)
//   concentrated_link_ready_and_rev_i  downstream ready
module bsg_wormhole_concentrator_in_cid
   import bsg_wormhole_concentrator_in_cid_pkg::*;
#(
   parameter int unsigned flit_width_p = 16,
   parameter int unsigned len_width_p  = 3,
   parameter int unsigned cord_width_p = 4,
   parameter int unsigned cid_width_p  = 3,
   parameter int unsigned num_in_p     = 2,
   parameter int unsigned fifo_els_p   = 2,
   parameter int unsigned arb_mode_p   = 0,
   parameter int unsigned stamp_cid_p  = 1
) (
   input  logic                             clk_i,
   input  logic                             reset_n_i,
   input  logic [num_in_p-1:0]              links_v_i,
   input  logic [num_in_p*flit_width_p-1:0] links_data_i,
   output logic [num_in_p-1:0]              links_ready_and_rev_o,
   output logic                             concentrated_link_v_o,
   output logic [flit_width_p-1:0]          concentrated_link_data_o,
   input  logic                             concentrated_link_ready_and_rev_i
);

   localparam int unsigned IdxW = safe_clog2(num_in_p);

   logic [num_in_p-1:0]     w_req;
   logic [num_in_p-1:0]     w_rel;
   logic [num_in_p-1:0]     w_is_hdr;
   logic [num_in_p-1:0]     w_yumi;
   logic [num_in_p-1:0]     w_sel_oh;
   logic [flit_width_p-1:0] w_head [num_in_p];

   arb_state_e              r_arb_state;
   logic [IdxW-1:0]         r_lock_idx;
   logic [IdxW-1:0]         r_rr_ptr;
   logic [IdxW-1:0]         w_grant_idx;
   logic [IdxW-1:0]         w_sel_idx;
   logic                    w_grant_v;
   logic                    w_sel_v;
   logic                    w_sel_is_hdr;
   logic                    w_release;
   logic [flit_width_p-1:0] w_sel_data;
   int unsigned             w_rr_j;

   function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] i);
      return (i == IdxW'(num_in_p - 1)) ? '0 : i + 1'b1;
   endfunction

   for (genvar gi = 0; gi < num_in_p; gi++) begin : g_ch
      bsg_wormhole_concentrator_in_cid_ch #(
         .flit_width_p (flit_width_p),
         .len_width_p  (len_width_p),
         .cord_width_p (cord_width_p),
         .cid_width_p  (cid_width_p),
         .fifo_els_p   (fifo_els_p)
      ) u_ch (
         .i_clk     (clk_i),
         .i_reset_n (reset_n_i),
         .i_v       (links_v_i[gi]),
         .i_data    (links_data_i[gi*flit_width_p +: flit_width_p]),
         .o_ready   (links_ready_and_rev_o[gi]),
         .o_v       (w_req[gi]),
         .o_data    (w_head[gi]),
         .o_is_hdr  (w_is_hdr[gi]),
         .i_yumi    (w_yumi[gi]),
         .o_release (w_rel[gi])
      );

      assign w_sel_oh[gi] = w_sel_v && (w_sel_idx == IdxW'(gi));
      assign w_yumi[gi]   = w_sel_oh[gi] & concentrated_link_ready_and_rev_i;
   end

   // Combinational grant so a waiting header goes out the cycle after a release.
   always_comb begin
      w_grant_v   = 1'b0;
      w_grant_idx = '0;
      w_rr_j      = 0;
      if (arb_mode_p == ArbFixedPriority) begin
         for (int i = int'(num_in_p) - 1; i >= 0; i--) begin
            if (w_req[i]) begin
               w_grant_v   = 1'b1;
               w_grant_idx = IdxW'(i);
            end
         end
      end else begin
         for (int unsigned k = 0; k < num_in_p; k++) begin
            w_rr_j = (32'(r_rr_ptr) + k) % num_in_p;
            if (!w_grant_v && w_req[w_rr_j]) begin
               w_grant_v   = 1'b1;
               w_grant_idx = IdxW'(w_rr_j);
            end
         end
      end
   end

   assign w_sel_idx = (r_arb_state == ArbLocked) ? r_lock_idx : w_grant_idx;
   assign w_sel_v   = (r_arb_state == ArbLocked) ? w_req[w_sel_idx] : w_grant_v;
   // Only the selected channel can be dequeued, so any release belongs to it.
   assign w_release = |w_rel;

   // One-hot AND-OR mux; all-zero select yields zero data.
   always_comb begin
      w_sel_data   = '0;
      w_sel_is_hdr = 1'b0;
      for (int unsigned i = 0; i < num_in_p; i++) begin
         w_sel_data   = w_sel_data | (w_head[i] & {flit_width_p{w_sel_oh[i]}});
         w_sel_is_hdr = w_sel_is_hdr | (w_is_hdr[i] & w_sel_oh[i]);
      end
   end

   always_comb begin
      concentrated_link_data_o = w_sel_data;
      if ((stamp_cid_p != 0) && w_sel_is_hdr) begin
         concentrated_link_data_o[cord_width_p +: cid_width_p] = cid_width_p'(w_sel_idx);
      end
   end

   assign concentrated_link_v_o = w_sel_v;

   // Lock on grant unless the packet finishes in the same cycle (len = 0 header);
   // the round-robin pointer moves only on packet completion.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_arb_state <= ArbFree;
         r_lock_idx  <= '0;
         r_rr_ptr    <= '0;
      end else begin
         unique case (r_arb_state)
            ArbFree: begin
               if (w_grant_v) begin
                  if (w_release) begin
                     r_rr_ptr <= idx_inc(w_grant_idx);
                  end else begin
                     r_arb_state <= ArbLocked;
                     r_lock_idx  <= w_grant_idx;
                  end
               end
            end
            ArbLocked: begin
               if (w_release) begin
                  r_arb_state <= ArbFree;
                  r_rr_ptr    <= idx_inc(r_lock_idx);
               end
            end
            default: r_arb_state <= ArbFree;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_wormhole_concentrator_in_cid.sv
// Directed bench for the cid-stamping wormhole concentrator. Three instances
// share the input stimulus: a (round-robin, stamping), b (fixed priority,
// stamping), c (round-robin, pass-through). Header: cord[3:0] cid[6:4] len[9:7].
module tb_bsg_wormhole_concentrator_in_cid;

   localparam int unsigned FW = 16;
   localparam int unsigned NI = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [NI-1:0]    lv;
   logic [NI*FW-1:0] ld;
   logic             down_rdy;
   logic [NI-1:0]    rdy_a, rdy_b, rdy_c;
   logic             v_a, v_b, v_c;
   logic [FW-1:0]    d_a, d_b, d_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bsg_wormhole_concentrator_in_cid #(
      .flit_width_p(FW), .len_width_p(3), .cord_width_p(4), .cid_width_p(3),
      .num_in_p(NI), .fifo_els_p(4), .arb_mode_p(0), .stamp_cid_p(1)
   ) dut_a (
      .clk_i(clk), .reset_n_i(reset_n), .links_v_i(lv), .links_data_i(ld),
      .links_ready_and_rev_o(rdy_a), .concentrated_link_v_o(v_a),
      .concentrated_link_data_o(d_a), .concentrated_link_ready_and_rev_i(down_rdy)
   );

   bsg_wormhole_concentrator_in_cid #(
      .flit_width_p(FW), .len_width_p(3), .cord_width_p(4), .cid_width_p(3),
      .num_in_p(NI), .fifo_els_p(4), .arb_mode_p(1), .stamp_cid_p(1)
   ) dut_b (
      .clk_i(clk), .reset_n_i(reset_n), .links_v_i(lv), .links_data_i(ld),
      .links_ready_and_rev_o(rdy_b), .concentrated_link_v_o(v_b),
      .concentrated_link_data_o(d_b), .concentrated_link_ready_and_rev_i(down_rdy)
   );

   bsg_wormhole_concentrator_in_cid #(
      .flit_width_p(FW), .len_width_p(3), .cord_width_p(4), .cid_width_p(3),
      .num_in_p(NI), .fifo_els_p(4), .arb_mode_p(0), .stamp_cid_p(0)
   ) dut_c (
      .clk_i(clk), .reset_n_i(reset_n), .links_v_i(lv), .links_data_i(ld),
      .links_ready_and_rev_o(rdy_c), .concentrated_link_v_o(v_c),
      .concentrated_link_data_o(d_c), .concentrated_link_ready_and_rev_i(down_rdy)
   );

   function automatic logic [FW-1:0] mk_hdr(input logic [5:0] pl, input logic [2:0] len,
                                            input logic [2:0] cid, input logic [3:0] cord);
      return {pl, len, cid, cord};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input int idx, input logic v, input logic [FW-1:0] data);
      lv[idx] = v;
      ld[idx*FW +: FW] = data;
   endtask

   task automatic clr_in;
      lv = '0;
      ld = '0;
   endtask

   task automatic do_reset;
      reset_n  = 1'b0;
      down_rdy = 1'b1;
      clr_in();
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset;
      reset_n  = 1'b0;
      down_rdy = 1'b1;
      lv = '1;
      ld = {4{16'hC3A5}};
      step();
      step();
      #1;
      checks++;
      if (rdy_a !== 4'h0) begin
         errors++; $display("FAIL reset_ready: got %h want 0", rdy_a);
      end
      checks++;
      if (v_a !== 1'b0 || v_b !== 1'b0 || v_c !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b%b%b want 000", v_a, v_b, v_c);
      end
      checks++;
      if (d_a !== '0) begin
         errors++; $display("FAIL reset_data: got %h want 0", d_a);
      end
      reset_n = 1'b1;
      clr_in();
      step();
      #1;
      checks++;
      if (rdy_a !== 4'hF || rdy_b !== 4'hF || rdy_c !== 4'hF) begin
         errors++; $display("FAIL post_reset_ready: got %h %h %h want f", rdy_a, rdy_b, rdy_c);
      end
      checks++;
      if (v_a !== 1'b0) begin
         errors++; $display("FAIL post_reset_empty: got v=%b want 0", v_a);
      end
   endtask

   task automatic test_single_packet;
      logic [FW-1:0] f   [4];
      logic [FW-1:0] exp [4];
      do_reset();
      f   = '{mk_hdr(6'h15, 3'd3, 3'd0, 4'hA), 16'hB071, 16'h4F75, 16'hFFFF};
      exp = '{mk_hdr(6'h15, 3'd3, 3'd2, 4'hA), 16'hB071, 16'h4F75, 16'hFFFF};
      for (int k = 0; k < 6; k++) begin
         if (k < 4) set_in(2, 1'b1, f[k]);
         else clr_in();
         #1;
         if (k >= 1 && k <= 4) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== exp[k-1]) begin
               errors++;
               $display("FAIL single_flit%0d: got v=%b d=%h want v=1 d=%h", k - 1, v_a, d_a,
                        exp[k-1]);
            end
         end else if (k == 5) begin
            checks++;
            if (v_a !== 1'b0) begin
               errors++; $display("FAIL single_idle: got v=%b want 0", v_a);
            end
         end
         step();
      end
   endtask

   task automatic test_rr_serialise;
      logic [FW-1:0] exp [6];
      do_reset();
      exp = '{mk_hdr(6'h01, 3'd2, 3'd0, 4'h1), 16'h0A01, 16'h0A02,
              mk_hdr(6'h02, 3'd2, 3'd1, 4'h2), 16'h1B01, 16'h1B02};
      for (int k = 0; k < 8; k++) begin
         case (k)
            0: begin
               set_in(0, 1'b1, mk_hdr(6'h01, 3'd2, 3'd3, 4'h1));
               set_in(1, 1'b1, mk_hdr(6'h02, 3'd2, 3'd3, 4'h2));
            end
            1: begin set_in(0, 1'b1, 16'h0A01); set_in(1, 1'b1, 16'h1B01); end
            2: begin set_in(0, 1'b1, 16'h0A02); set_in(1, 1'b1, 16'h1B02); end
            default: clr_in();
         endcase
         #1;
         if (k >= 1 && k <= 6) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== exp[k-1]) begin
               errors++;
               $display("FAIL rr_flit%0d: got v=%b d=%h want v=1 d=%h", k - 1, v_a, d_a,
                        exp[k-1]);
            end
         end else if (k == 7) begin
            checks++;
            if (v_a !== 1'b0) begin
               errors++; $display("FAIL rr_idle: got v=%b want 0", v_a);
            end
         end
         step();
      end
   endtask

   // Input 0 streams len=0 packets every cycle, input 3 offers one packet.
   task automatic test_starvation;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         if (k < 11) set_in(0, 1'b1, mk_hdr(6'(k), 3'd0, 3'd0, 4'h3));
         else set_in(0, 1'b0, '0);
         if (k == 0) set_in(3, 1'b1, mk_hdr(6'h3F, 3'd0, 3'd0, 4'hC));
         else set_in(3, 1'b0, '0);
         #1;
         if (k >= 1 && k <= 11) begin
            checks++;
            if (v_b !== 1'b1 || d_b !== mk_hdr(6'(k - 1), 3'd0, 3'd0, 4'h3)) begin
               errors++;
               $display("FAIL fixed_prio%0d: got v=%b d=%h want v=1 d=%h", k, v_b, d_b,
                        mk_hdr(6'(k - 1), 3'd0, 3'd0, 4'h3));
            end
         end
         if (k == 1) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== mk_hdr(6'h00, 3'd0, 3'd0, 4'h3)) begin
               errors++; $display("FAIL rr_first: got v=%b d=%h want v=1 d=%h", v_a, d_a,
                                  mk_hdr(6'h00, 3'd0, 3'd0, 4'h3));
            end
         end
         if (k == 2) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== mk_hdr(6'h3F, 3'd0, 3'd3, 4'hC)) begin
               errors++; $display("FAIL rr_serves_in3: got v=%b d=%h want v=1 d=%h", v_a, d_a,
                                  mk_hdr(6'h3F, 3'd0, 3'd3, 4'hC));
            end
         end
         step();
      end
      clr_in();
   endtask

   // len=5 packet on input 1; downstream stalls 4 cycles then toggles 1/0.
   task automatic test_backpressure;
      logic [FW-1:0] f   [6];
      logic [FW-1:0] exp [6];
      int cnt  = 0;
      int sent = 0;
      int rcv  = 0;
      logic enq;
      logic deq;
      do_reset();
      f   = '{mk_hdr(6'h09, 3'd5, 3'd0, 4'h5), 16'h1111, 16'h2222, 16'h3333, 16'h4444,
              16'h5555};
      exp = '{mk_hdr(6'h09, 3'd5, 3'd1, 4'h5), 16'h1111, 16'h2222, 16'h3333, 16'h4444,
              16'h5555};
      for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
         down_rdy = (cyc >= 4) && (cyc % 2 == 0);
         if (sent < 6) set_in(1, 1'b1, f[sent]);
         else set_in(1, 1'b0, '0);
         #1;
         checks++;
         if (rdy_a[1] !== (cnt < 4)) begin
            errors++; $display("FAIL bp_ready c%0d: got %b want %b", cyc, rdy_a[1], cnt < 4);
         end
         checks++;
         if (v_a !== (cnt > 0)) begin
            errors++; $display("FAIL bp_valid c%0d: got %b want %b", cyc, v_a, cnt > 0);
         end
         enq = (sent < 6) && (cnt < 4);
         deq = (cnt > 0) && down_rdy;
         if (deq) begin
            checks++;
            if (d_a !== exp[rcv]) begin
               errors++; $display("FAIL bp_flit%0d: got %h want %h", rcv, d_a, exp[rcv]);
            end
            rcv++;
         end
         if (enq) sent++;
         cnt = cnt + int'(enq) - int'(deq);
         step();
      end
      #1;
      checks++;
      if (rcv !== 6) begin
         errors++; $display("FAIL bp_timeout: got %0d flits want 6", rcv);
      end
      checks++;
      if (v_a !== 1'b0) begin
         errors++; $display("FAIL bp_drained: got v=%b want 0", v_a);
      end
      down_rdy = 1'b1;
   endtask

   task automatic test_no_stamp;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         if (k == 0) set_in(2, 1'b1, mk_hdr(6'h2A, 3'd1, 3'd5, 4'h6));
         else if (k == 1) set_in(2, 1'b1, 16'h1234);
         else clr_in();
         #1;
         if (k == 1) begin
            checks++;
            if (v_c !== 1'b1 || d_c !== mk_hdr(6'h2A, 3'd1, 3'd5, 4'h6)) begin
               errors++; $display("FAIL nostamp_hdr: got v=%b d=%h want v=1 d=%h", v_c, d_c,
                                  mk_hdr(6'h2A, 3'd1, 3'd5, 4'h6));
            end
            checks++;
            if (d_a !== mk_hdr(6'h2A, 3'd1, 3'd2, 4'h6)) begin
               errors++; $display("FAIL stamp_hdr: got %h want %h", d_a,
                                  mk_hdr(6'h2A, 3'd1, 3'd2, 4'h6));
            end
         end else if (k == 2) begin
            checks++;
            if (v_c !== 1'b1 || d_c !== 16'h1234 || d_a !== 16'h1234) begin
               errors++; $display("FAIL nostamp_body: got c=%h a=%h want 1234", d_c, d_a);
            end
         end
         step();
      end
   endtask

   // Advance the pointer to 3, reset mid-body, then confirm input 0 wins again.
   task automatic test_reset_mid_body;
      logic [FW-1:0] exp [4];
      do_reset();
      exp = '{mk_hdr(6'h33, 3'd1, 3'd0, 4'h3), 16'hA5A5,
              mk_hdr(6'h34, 3'd1, 3'd3, 4'h4), 16'h5A5A};
      for (int k = 0; k < 11; k++) begin
         reset_n = (k != 4);
         clr_in();
         case (k)
            0: set_in(2, 1'b1, mk_hdr(6'h11, 3'd0, 3'd0, 4'h1));
            1: set_in(0, 1'b1, mk_hdr(6'h22, 3'd3, 3'd0, 4'h2));
            2: set_in(0, 1'b1, 16'hD001);
            3: set_in(0, 1'b1, 16'hD002);
            5: begin
               set_in(0, 1'b1, mk_hdr(6'h33, 3'd1, 3'd0, 4'h3));
               set_in(3, 1'b1, mk_hdr(6'h34, 3'd1, 3'd0, 4'h4));
            end
            6: begin set_in(0, 1'b1, 16'hA5A5); set_in(3, 1'b1, 16'h5A5A); end
            default: ;
         endcase
         #1;
         if (k == 1) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== mk_hdr(6'h11, 3'd0, 3'd2, 4'h1)) begin
               errors++; $display("FAIL rm_in2: got v=%b d=%h", v_a, d_a);
            end
         end
         if (k == 3) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== 16'hD001) begin
               errors++; $display("FAIL rm_body1: got v=%b d=%h want d001", v_a, d_a);
            end
         end
         if (k == 4) begin
            checks++;
            if (v_a !== 1'b0 || rdy_a !== 4'h0) begin
               errors++; $display("FAIL rm_in_reset: got v=%b rdy=%h want 0 0", v_a, rdy_a);
            end
         end
         if (k == 5) begin
            checks++;
            if (v_a !== 1'b0 || rdy_a !== 4'hF) begin
               errors++; $display("FAIL rm_after: got v=%b rdy=%h want 0 f", v_a, rdy_a);
            end
         end
         if (k >= 6 && k <= 9) begin
            checks++;
            if (v_a !== 1'b1 || d_a !== exp[k-6]) begin
               errors++; $display("FAIL rm_flit%0d: got v=%b d=%h want v=1 d=%h", k - 6, v_a,
                                  d_a, exp[k-6]);
            end
         end
         if (k == 10) begin
            checks++;
            if (v_a !== 1'b0) begin
               errors++; $display("FAIL rm_idle: got v=%b want 0", v_a);
            end
         end
         step();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b0;
      down_rdy = 1'b1;
      clr_in();
      test_reset();
      test_single_packet();
      test_rr_serialise();
      test_starvation();
      test_backpressure();
      test_no_stamp();
      test_reset_mid_body();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
